// File: rtl/ysyx_22051013_pkg.sv
// Shared definitions for the ysyx_22051013 pipeline: occupancy encodings and default field widths.
package ysyx_22051013;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int INST_W    = 32;
  localparam int PC_W      = 64;
  localparam int REGADDR_W = 5;
  localparam int DATA_W    = 64;

endpackage

// File: rtl/ysyx_22051013_fwd_match.sv
// Single-port forwarding matcher over the two held entries; the younger skid entry wins.
module ysyx_22051013_fwd_match #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              m_valid,
  input  logic              m_rd_ena,
  input  logic [ADDR_W-1:0] m_rd_addr,
  input  logic [DATA_W-1:0] m_rd_data,
  input  logic              s_valid,
  input  logic              s_rd_ena,
  input  logic [ADDR_W-1:0] s_rd_addr,
  input  logic [DATA_W-1:0] s_rd_data,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic addr_nz;
  logic m_hit;
  logic s_hit;

  always_comb begin
    addr_nz = |addr;
    m_hit   = addr_nz & m_valid & m_rd_ena & (m_rd_addr == addr);
    s_hit   = addr_nz & s_valid & s_rd_ena & (s_rd_addr == addr);
    hit     = m_hit | s_hit;
    data    = '0;
    if (s_hit) begin
      data = s_rd_data;
    end else if (m_hit) begin
      data = m_rd_data;
    end
  end

endmodule

// File: rtl/ysyx_22051013_stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer, flush and forwarding lookup.
module ysyx_22051013_stage_skid_reg
  import ysyx_22051013::*;
#(
  parameter int PAYLOAD_W = 160,
  parameter int RD_ADDR_W = REGADDR_W,
  parameter int RD_DATA_W = DATA_W,
  parameter int N_LOOKUP  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PAYLOAD_W-1:0]          in_payload,
  input  logic                          in_rd_ena,
  input  logic [RD_ADDR_W-1:0]          in_rd_addr,
  input  logic [RD_DATA_W-1:0]          in_rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PAYLOAD_W-1:0]          out_payload,
  output logic                          out_rd_ena,
  output logic [RD_ADDR_W-1:0]          out_rd_addr,
  output logic [RD_DATA_W-1:0]          out_rd_data,
  input  logic [N_LOOKUP*RD_ADDR_W-1:0] lookup_addr,
  output logic [N_LOOKUP-1:0]           lookup_hit,
  output logic [N_LOOKUP*RD_DATA_W-1:0] lookup_data,
  output logic [1:0]                    occupancy
);

  logic                 m_valid_q, m_valid_d;
  logic [PAYLOAD_W-1:0] m_payload_q, m_payload_d;
  logic                 m_rd_ena_q, m_rd_ena_d;
  logic [RD_ADDR_W-1:0] m_rd_addr_q, m_rd_addr_d;
  logic [RD_DATA_W-1:0] m_rd_data_q, m_rd_data_d;
  logic                 s_valid_q, s_valid_d;
  logic [PAYLOAD_W-1:0] s_payload_q, s_payload_d;
  logic                 s_rd_ena_q, s_rd_ena_d;
  logic [RD_ADDR_W-1:0] s_rd_addr_q, s_rd_addr_d;
  logic [RD_DATA_W-1:0] s_rd_data_q, s_rd_data_d;
  occ_e                 occ_q, occ_d;
  logic                 in_fire;
  logic                 out_fire;

  // in_ready depends only on the skid flop, which breaks the out_ready -> in_ready path.
  assign in_ready    = ~s_valid_q;
  assign out_valid   = m_valid_q;
  assign out_payload = m_payload_q;
  assign out_rd_ena  = m_valid_q & m_rd_ena_q;
  assign out_rd_addr = m_rd_addr_q;
  assign out_rd_data = m_rd_data_q;
  assign occupancy   = occ_q;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = m_valid_q & out_ready;

  always_comb begin
    m_valid_d   = m_valid_q;
    m_payload_d = m_payload_q;
    m_rd_ena_d  = m_rd_ena_q;
    m_rd_addr_d = m_rd_addr_q;
    m_rd_data_d = m_rd_data_q;
    s_valid_d   = s_valid_q;
    s_payload_d = s_payload_q;
    s_rd_ena_d  = s_rd_ena_q;
    s_rd_addr_d = s_rd_addr_q;
    s_rd_data_d = s_rd_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!s_valid_q && in_fire && (!m_valid_q || out_fire)) begin
      // Empty, or one entry leaving as a new one arrives: input goes straight to M.
      m_valid_d   = 1'b1;
      m_payload_d = in_payload;
      m_rd_ena_d  = in_rd_ena;
      m_rd_addr_d = in_rd_addr;
      m_rd_data_d = in_rd_data;
    end else if (m_valid_q && !s_valid_q && in_fire) begin
      s_valid_d   = 1'b1;
      s_payload_d = in_payload;
      s_rd_ena_d  = in_rd_ena;
      s_rd_addr_d = in_rd_addr;
      s_rd_data_d = in_rd_data;
    end else if (s_valid_q && out_fire) begin
      m_valid_d   = 1'b1;
      m_payload_d = s_payload_q;
      m_rd_ena_d  = s_rd_ena_q;
      m_rd_addr_d = s_rd_addr_q;
      m_rd_data_d = s_rd_data_q;
      s_valid_d   = 1'b0;
    end else if (out_fire) begin
      m_valid_d = 1'b0;
    end
    occ_d = s_valid_d ? OCC_FULL : (m_valid_d ? OCC_ONE : OCC_EMPTY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q   <= 1'b0;
      m_payload_q <= '0;
      m_rd_ena_q  <= 1'b0;
      m_rd_addr_q <= '0;
      m_rd_data_q <= '0;
      s_valid_q   <= 1'b0;
      s_payload_q <= '0;
      s_rd_ena_q  <= 1'b0;
      s_rd_addr_q <= '0;
      s_rd_data_q <= '0;
      occ_q       <= OCC_EMPTY;
    end else begin
      m_valid_q   <= m_valid_d;
      m_payload_q <= m_payload_d;
      m_rd_ena_q  <= m_rd_ena_d;
      m_rd_addr_q <= m_rd_addr_d;
      m_rd_data_q <= m_rd_data_d;
      s_valid_q   <= s_valid_d;
      s_payload_q <= s_payload_d;
      s_rd_ena_q  <= s_rd_ena_d;
      s_rd_addr_q <= s_rd_addr_d;
      s_rd_data_q <= s_rd_data_d;
      occ_q       <= occ_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LOOKUP; gi++) begin : g_lookup
      ysyx_22051013_fwd_match #(
        .ADDR_W(RD_ADDR_W),
        .DATA_W(RD_DATA_W)
      ) u_match (
        .addr      (lookup_addr[gi*RD_ADDR_W +: RD_ADDR_W]),
        .m_valid   (m_valid_q),
        .m_rd_ena  (m_rd_ena_q),
        .m_rd_addr (m_rd_addr_q),
        .m_rd_data (m_rd_data_q),
        .s_valid   (s_valid_q),
        .s_rd_ena  (s_rd_ena_q),
        .s_rd_addr (s_rd_addr_q),
        .s_rd_data (s_rd_data_q),
        .hit       (lookup_hit[gi]),
        .data      (lookup_data[gi*RD_DATA_W +: RD_DATA_W])
      );
    end
  endgenerate

endmodule
